pwm_seq: RTL
============

PWM_SEQ -- requirements
Module: pwm_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pattern entries (power of 2, minimum 2).
REQ-002 SHALL have parameter W, default 4, meaning the bit width of the delay and width fields.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  pattern-table write strobe.
REQ-006 SHALL have port wr_addr  input  log2(DEPTH)  table entry written.
REQ-007 SHALL have port wr_d  input  W  delay (low) cycles for the entry.
REQ-008 SHALL have port wr_w  input  W  width (high) cycles for the entry.
REQ-009 SHALL have port len  input  log2(DEPTH)+1  number of entries to play; sampled on an accepted start.
REQ-010 SHALL have port loop  input  1  1 = repeat the sequence; 0 = one-shot; sampled on an accepted start.
REQ-011 SHALL have port start  input  1  single-cycle request to begin playback.
REQ-012 SHALL have port stop  input  1  single-cycle request to abort playback.
REQ-013 SHALL have port busy  output  1  high while playback is active.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a one-shot sequence completes.
REQ-015 SHALL have port cur_idx  output  log2(DEPTH)  index of the entry currently playing.
REQ-016 SHALL have port pulse  output  1  PWM output.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; start in IDLE moves to RUN on the next edge with cur_idx=0 and cnt=0.
REQ-018 SHALL latch d and w of an entry into working registers on the cycle that entry begins; table writes to the playing entry take effect on its next visit.
REQ-019 SHALL drive pulse = (cnt >= d) && (cnt < d+w) in RUN, using a W+1-bit sum with no overflow; pulse SHALL be registered.
REQ-020 SHALL end each entry when cnt == max(d+w,1)-1; an entry with d=w=0 occupies exactly one low cycle.
REQ-021 SHALL advance cur_idx to the next entry in the cycle after an entry ends, with no gap cycles.
REQ-022 SHALL, at the end of entry len-1, wrap to entry 0 if loop=1, or otherwise return to IDLE with done high for one cycle.
REQ-023 SHALL treat len=0 as len=1 and len>DEPTH as DEPTH.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, on stop in RUN, enter IDLE on the next edge with pulse=0, busy=0 and done=0; stop and start in the same cycle means stop wins.
REQ-026 SHALL accept table writes in any state without disturbing playback timing.

Reset
REQ-027 SHALL, on reset assertion, asynchronously force state=IDLE, busy=0, done=0, pulse=0, cur_idx=0 and cnt=0; all table entries SHALL clear to d=0, w=0.
REQ-028 SHALL, on reset release mid-playback, stay in IDLE until a new start.

Configuration
REQ-029 SHALL compile in input pol (1 bit) when PWM_SEQ_POLARITY_EN is defined; pol=1 inverts pulse in all states, so idle level = pol, and reset drives pulse to pol.
REQ-030 SHALL, without PWM_SEQ_POLARITY_EN, have no pol port and keep pulse active-high with idle level 0.

Structure
REQ-031 SHALL place DEPTH/W defaults, the state enum (IDLE, RUN) and index-width constants in package pwm_seq_pkg.
REQ-032 SHALL implement the per-entry delay/width timer (cnt, compare, end-of-entry flag) as sub-module pwm_seq_timer.

Verification
REQ-033 SHALL test: entries {d=2,w=3},{d=1,w=1}, len=2, loop=0 -> pulse 0,0,1,1,1,0,1 then done for one cycle and busy low.
REQ-034 SHALL test: entry {0,0}, len=1, loop=1 -> pulse stays 0, cur_idx stays 0, busy stays 1, no done.
REQ-035 SHALL test: entry {15,15}, len=1 -> 15 low cycles, then 15 high cycles, then done (no width overflow).
REQ-036 SHALL test: loop=1 running, stop on the 3rd high cycle -> next cycle pulse=0, busy=0, done=0; start and stop together in IDLE -> stays IDLE.
REQ-037 SHALL test: write entry 1 to {4,4} while entry 1 is playing as {1,1} -> current pass uses {1,1}, next loop pass uses {4,4}.
REQ-038 SHALL test: with PWM_SEQ_POLARITY_EN, pol=1 and reset asserted mid-run -> pulse=1 immediately (asynchronous), busy=0.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared defaults, FSM state type and index-width helper for the pwm_seq pattern player.
package pwm_seq_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int W_DEF     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Table index width; DEPTH is a power of two >= 2.
  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int IDX_W_DEF = idx_w(DEPTH_DEF);

endpackage

// File: rtl/pwm_seq_timer.sv
// Per-entry delay/width timer: working copy of {d,w}, cycle counter, registered pulse
// and the end-of-entry flag consumed by the sequencer.
module pwm_seq_timer
  import pwm_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_nxt,
  input  logic         load,
  input  logic [W-1:0] ld_d,
  input  logic [W-1:0] ld_w,
  output logic         pulse_raw,
  output logic         ent_end
);

  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W:0]   cnt_q, cnt_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] w_q, w_d;
  logic         pulse_q, pulse_d;
  logic [W:0]   sum_q, sum_d, last_q;

  // d+w is carried in W+1 bits so {max,max} never wraps.
  always_comb begin
    sum_q   = {1'b0, d_q} + {1'b0, w_q};
    last_q  = (sum_q == '0) ? '0 : (sum_q - ONE);
    ent_end = (cnt_q == last_q);
  end

  always_comb begin
    d_d   = d_q;
    w_d   = w_q;
    cnt_d = cnt_q;
    if (!run_nxt) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = '0;
      d_d   = ld_d;
      w_d   = ld_w;
    end else begin
      cnt_d = cnt_q + ONE;
    end
    sum_d   = {1'b0, d_d} + {1'b0, w_d};
    pulse_d = run_nxt && (cnt_d >= {1'b0, d_d}) && (cnt_d < sum_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      d_q     <= '0;
      w_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      w_q     <= w_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_raw = pulse_q;

endmodule

// File: rtl/pwm_seq.sv
// Table-driven PWM sequencer: plays len entries of {delay low, width high}, one-shot or looped.
// Optional PWM_SEQ_POLARITY_EN adds input pol that inverts pulse (idle/reset level = pol).
module pwm_seq
  import pwm_seq_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int W     = W_DEF,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_d,
  input  logic [W-1:0]     wr_w,
  input  logic [IDX_W:0]   len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
`ifdef PWM_SEQ_POLARITY_EN
  input  logic             pol,
`endif
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] cur_idx,
  output logic             pulse
);

  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic                      loop_q, loop_d;
  logic                      done_q, done_d;
  logic [DEPTH-1:0][W-1:0]   dly_q, dly_d;
  logic [DEPTH-1:0][W-1:0]   wid_q, wid_d;

  logic [IDX_W:0]   len_m1;
  logic [IDX_W-1:0] len_last;
  logic             load;
  logic             run_nxt;
  logic             ent_end;
  logic             pulse_raw;

  // Clamp len into 1..DEPTH and keep it as the index of the final entry.
  always_comb begin
    len_m1 = len - LEN_ONE;
    if (len == '0)          len_last = '0;
    else if (len > DEPTH_L) len_last = IDX_MAX;
    else                    len_last = len_m1[IDX_W-1:0];
  end

  always_comb begin
    dly_d = dly_q;
    wid_d = wid_q;
    if (wr_en) begin
      dly_d[wr_addr] = wr_d;
      wid_d[wr_addr] = wr_w;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          idx_d   = '0;
          last_d  = len_last;
          loop_d  = loop;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (ent_end) begin
          if (idx_q == last_q) begin
            if (loop_q) begin
              idx_d = '0;
              load  = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    run_nxt = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      dly_q   <= '0;
      wid_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
    end
  end

  // Entry parameters are copied at entry start, so a write to the playing entry waits for its next visit.
  pwm_seq_timer #(.W(W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run_nxt   (run_nxt),
    .load      (load),
    .ld_d      (dly_q[idx_d]),
    .ld_w      (wid_q[idx_d]),
    .pulse_raw (pulse_raw),
    .ent_end   (ent_end)
  );

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign cur_idx = idx_q;

`ifdef PWM_SEQ_POLARITY_EN
  assign pulse = pulse_raw ^ pol;
`else
  assign pulse = pulse_raw;
`endif

endmodule
